lfsr32_e: RTL and testbench
===========================

# lfsr32_e

32-bit maximal-length Fibonacci linear feedback shift register with a clock enable. It is a free-running pseudo-random source for stimulus generation, for example random priorities and keys in the hardware priority-queue test environment. The block advances one state per enabled clock and exposes the full 32-bit state as its output.

## Interface
Parameters:
- SEED, 32'h0000_0001, reset/reload value of the state register. A value of 0 is illegal and is replaced by 32'h0000_0001 at elaboration.

Ports:
- clk  input  1  clock; all state updates occur on its rising edge
- rst  input  1  reset; one clock, reset is asynchronous and active-low (rst = 0 resets)
- enb  input  1  step enable; the state advances only on clock edges where enb = 1
- q  output  32  current LFSR state, driven directly from the state register

## Operation
- Polynomial: x^32 + x^22 + x^2 + x + 1 (taps 32, 22, 2, 1), which gives a maximal period of 2^32 − 1.
- Feedback bit: fb = q[31] ^ q[21] ^ q[1] ^ q[0].
- Step (shift left, feedback into the LSB): q_next = {q[30:0], fb}.
- When enb = 0 the state holds unchanged.
- Lock-up protection: the all-zero state is illegal. If q ever equals 0 (for example after an SEU or a forced value), the next edge loads the effective SEED regardless of enb.
- Reset:
  - While rst = 0, q = effective SEED (32'h0000_0001 by default).
  - This takes priority over enb and over lock-up recovery.
- q is purely registered; there is no combinational path from enb to q.
- No other state exists. The output is fully determined by the reset value and the count of enabled edges.

## Timing
- Reset assertion: asynchronous; q takes SEED immediately, without waiting for a clock edge.
- Reset deassertion: the first edge that can advance the state is the first rising edge at which rst = 1 and enb = 1.
- Latency: one cycle. An enabled edge at cycle n makes q(n+1) = step(q(n)).
- enb is sampled only at the rising clock edge; changes between edges have no effect.
- Reset mid-run: q returns to SEED at once. The sequence restarts from the beginning after deassertion.
- Default-seed sequence over the first enabled edges: 0x00000001, 0x00000003, 0x00000006, 0x0000000D, 0x0000001B, 0x00000036, 0x0000006D, …
- Wrap-around: after 2^32 − 1 enabled edges the state returns to SEED. The value 0 is never produced in normal operation.

## Test plan
- Reset value: hold rst = 0 with enb = 0, then run several clocks. Required: q = 0x00000001 throughout and immediately after deassertion.
- Enable gating: rst = 1 and enb = 0 for 10 clocks. Required: q stays 0x00000001. Toggling enb between clock edges must not change q.
- Sequence check: rst = 1 and enb = 1 for 20 clocks, compared each cycle against a reference model. Required: q = 0x3, 0x6, 0xD, 0x1B, 0x36, 0x6D, … The scoreboard must also confirm q ≠ 0 and that no value repeats.
- Intermittent enable: toggle enb every other cycle for 20 cycles. Required: q advances only on the enabled edges, and after 10 enabled edges q equals the 10th sequence value.
- Asynchronous reset mid-run: pull rst low between clock edges after 7 steps. Required: q = 0x00000001 before the next rising edge; after release with enb = 1 the sequence restarts at 0x3.
- Parameter and lock-up: instantiate with SEED = 0. Required: the reset value is 0x00000001. Force q to 0 and release it. Required: the next edge gives q = 0x00000001 even with enb = 0.

Source files
------------

// File: rtl/lfsr32_e.sv
// 32-bit maximal-length Fibonacci LFSR (x^32 + x^22 + x^2 + x + 1) with step enable.
// Free-running pseudo-random source; the all-zero state self-recovers to the seed.
module lfsr32_e #(
  parameter logic [31:0] SEED = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enb,
  output logic [31:0] q
);

  // A zero seed would lock the register up, so it is replaced at elaboration.
  localparam logic [31:0] SEEDEFF = (SEED == 32'h0) ? 32'h0000_0001 : SEED;

  logic [31:0] state;
  logic        fb;

  assign fb = state[31] ^ state[21] ^ state[1] ^ state[0];

  // Reset wins over lock-up recovery, which in turn wins over the enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= SEEDEFF;
    end else if (state == 32'h0) begin
      state <= SEEDEFF;
    end else if (enb) begin
      state <= {state[30:0], fb};
    end
  end

  assign q = state;

endmodule

// File: tb/tb_lfsr32_e.sv
// Randomised self-checking bench for lfsr32_e against a parity-based reference model.
// A second instance with SEED = 0 covers seed substitution and lock-up recovery.
module tb_lfsr32_e;

  localparam logic [31:0] TAPMASK = 32'h8020_0003;

  logic        clk;
  logic        rst;
  logic        enb;
  logic [31:0] q;
  logic [31:0] qZero;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] expQ;
  logic [31:0] seen[$];
  logic [31:0] seqTable[6];

  lfsr32_e dut (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .q  (q)
  );

  lfsr32_e #(.SEED(32'h0)) dutZero (
    .clk(clk),
    .rst(rst),
    .enb(enb),
    .q  (qZero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next state from the polynomial: shift left and append the parity of the tapped bits.
  function automatic logic [31:0] stepModel(input logic [31:0] v);
    return (v << 1) | {31'b0, ^(v & TAPMASK)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // One clock with the given enable; the model advances only on enabled, unreset edges.
  task automatic applyStimulus(input logic e);
    enb = e;
    @(posedge clk);
    #1;
    if (e && rst) expQ = stepModel(expQ);
  endtask

  task automatic checkUnique(input logic [31:0] v);
    int dup = 0;
    foreach (seen[i]) if (seen[i] == v) dup = 1;
    checkOutput("unique", dup, 0);
    seen.push_back(v);
  endtask

  initial begin
    logic [31:0] tenth;
    seqTable[0] = 32'h3;  seqTable[1] = 32'h6;  seqTable[2] = 32'hD;
    seqTable[3] = 32'h1B; seqTable[4] = 32'h36; seqTable[5] = 32'h6D;

    rst  = 1'b1;
    enb  = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async_reset_value", q, 32'h1);
    checkOutput("seed0_reset_value", qZero, 32'h1);
    expQ = 32'h1;

    // Reset held for several clocks, then released between edges.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1);
      checkOutput("reset_hold", q, 32'h1);
    end
    enb = 1'b0;
    rst = 1'b1;
    #1;
    checkOutput("after_deassert", q, 32'h1);

    // Enable gating, including a glitch on enb between edges.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b0);
      checkOutput("gated_hold", q, expQ);
    end
    enb = 1'b1;
    #2 enb = 1'b0;
    applyStimulus(1'b0);
    checkOutput("enb_glitch", q, 32'h1);

    // Continuous sequence from the default seed.
    seen.delete();
    seen.push_back(q);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1'b1);
      if (i < 6) checkOutput("seq_table", q, seqTable[i]);
      checkOutput("seq_model", q, expQ);
      checkOutput("seq_nonzero", (q == 32'h0) ? 32'h1 : 32'h0, 32'h0);
      checkUnique(q);
    end

    // Restart, then enable every other cycle.
    rst = 1'b0;
    #1 rst = 1'b1;
    expQ = 32'h1;
    tenth = 32'h1;
    for (int i = 0; i < 10; i++) tenth = stepModel(tenth);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(i[0] == 1'b0);
      checkOutput("intermittent", q, expQ);
    end
    checkOutput("intermittent_10th", q, tenth);

    // Random enable pattern.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)));
      checkOutput("random_enb", q, expQ);
    end

    // Asynchronous reset mid-run after seven steps.
    rst = 1'b0;
    #1 rst = 1'b1;
    expQ = 32'h1;
    for (int i = 0; i < 7; i++) applyStimulus(1'b1);
    checkOutput("pre_midreset", q, expQ);
    #2 rst = 1'b0;
    #1;
    checkOutput("midreset_async", q, 32'h1);
    checkOutput("midreset_async_seed0", qZero, 32'h1);
    applyStimulus(1'b1);
    checkOutput("midreset_held", q, 32'h1);
    rst = 1'b1;
    expQ = 32'h1;
    applyStimulus(1'b1);
    checkOutput("restart_first", q, 32'h3);
    applyStimulus(1'b1);
    checkOutput("restart_second", q, 32'h6);

    // Lock-up recovery on the SEED = 0 instance, with the enable low.
    enb = 1'b0;
    force dutZero.state = 32'h0;
    #1;
    release dutZero.state;
    applyStimulus(1'b0);
    checkOutput("lockup_recover", qZero, 32'h1);
    checkOutput("lockup_other_unaffected", q, expQ);
    applyStimulus(1'b1);
    checkOutput("after_lockup_step", qZero, 32'h3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
